// File: rtl/kbd_pkg.sv
// kbd_pkg: shared definitions for the keyboard scan-code controller.
//   state_e       - two-state sequencer encoding (wait for byte / process byte)
//   BreakCodeDef  - default break (release) prefix byte
//   ExtCodeDef    - default extended-key prefix byte
//   BcdW          - width of one BCD digit
//   bcd_digit_inc - one-digit BCD increment with carry in/out
package kbd_pkg;

   typedef enum logic [0:0] {
      StWait = 1'b0,
      StProc = 1'b1
   } state_e;

   localparam logic [7:0] BreakCodeDef = 8'hF0;
   localparam logic [7:0] ExtCodeDef   = 8'hE0;
   localparam int unsigned BcdW        = 4;

   // Returns {carry_out, digit_out}; 9 + carry wraps to 0 with carry out.
   function automatic logic [BcdW:0] bcd_digit_inc(input logic [BcdW-1:0] digit,
                                                    input logic           cin);
      logic [BcdW:0] res;
      if (!cin) begin
         res = {1'b0, digit};
      end else if (digit == 4'd9) begin
         res = {1'b1, 4'd0};
      end else begin
         res = {1'b0, digit + 4'd1};
      end
      return res;
   endfunction

endpackage

// File: rtl/kbd_ctrl_scancode_ascii.sv
// scancode_ascii: combinational scan-code set 2 to lowercase ASCII lookup.
//   scan_i  [7:0] - make code of the key (no prefix)
//   ascii_o [7:0] - ASCII for letters, digits, space and enter; 8'h00 otherwise
module scancode_ascii (
   input  logic [7:0] scan_i,
   output logic [7:0] ascii_o
);

   always_comb begin
      ascii_o = 8'h00;
      unique case (scan_i)
         8'h1C: ascii_o = 8'h61; // a
         8'h32: ascii_o = 8'h62;
         8'h21: ascii_o = 8'h63;
         8'h23: ascii_o = 8'h64;
         8'h24: ascii_o = 8'h65;
         8'h2B: ascii_o = 8'h66;
         8'h34: ascii_o = 8'h67;
         8'h33: ascii_o = 8'h68;
         8'h43: ascii_o = 8'h69;
         8'h3B: ascii_o = 8'h6A;
         8'h42: ascii_o = 8'h6B;
         8'h4B: ascii_o = 8'h6C;
         8'h3A: ascii_o = 8'h6D;
         8'h31: ascii_o = 8'h6E;
         8'h44: ascii_o = 8'h6F;
         8'h4D: ascii_o = 8'h70;
         8'h15: ascii_o = 8'h71;
         8'h2D: ascii_o = 8'h72;
         8'h1B: ascii_o = 8'h73;
         8'h2C: ascii_o = 8'h74;
         8'h3C: ascii_o = 8'h75;
         8'h2A: ascii_o = 8'h76;
         8'h1D: ascii_o = 8'h77;
         8'h22: ascii_o = 8'h78;
         8'h35: ascii_o = 8'h79;
         8'h1A: ascii_o = 8'h7A; // z
         8'h45: ascii_o = 8'h30; // 0
         8'h16: ascii_o = 8'h31;
         8'h1E: ascii_o = 8'h32;
         8'h26: ascii_o = 8'h33;
         8'h25: ascii_o = 8'h34;
         8'h2E: ascii_o = 8'h35;
         8'h36: ascii_o = 8'h36;
         8'h3D: ascii_o = 8'h37;
         8'h3E: ascii_o = 8'h38;
         8'h46: ascii_o = 8'h39; // 9
         8'h29: ascii_o = 8'h20; // space
         8'h5A: ascii_o = 8'h0D; // enter
         default: ascii_o = 8'h00;
      endcase
   end

endmodule

// File: rtl/kbd_ctrl.sv
// kbd_ctrl: pops scan-code bytes from the ps2_keyboard FIFO, decodes make/break/extended
// sequences, tracks the held key, counts new presses in BCD and flags FIFO overflow.
//   clk, resetn      - system clock, synchronous active-low reset
//   ps2_ready/data   - FIFO non-empty flag and head byte
//   ps2_overflow     - FIFO overflow indication
//   nextdata_n       - active-low one-cycle pop strobe
//   key_down/scan/ext/ascii - held-key status of the last pressed key
//   key_event        - one-cycle pulse per counted press
//   press_bcd        - BCD press count, digit 0 in [3:0]
//   err_overflow     - sticky overflow flag
module kbd_ctrl
   import kbd_pkg::*;
#(
   parameter int unsigned NDIGIT     = 2,
   parameter logic [7:0]  BREAK_CODE = BreakCodeDef,
   parameter logic [7:0]  EXT_CODE   = ExtCodeDef
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     ps2_ready,
   input  logic [7:0]               ps2_data,
   input  logic                     ps2_overflow,
   output logic                     nextdata_n,
   output logic                     key_down,
   output logic [7:0]               key_scan,
   output logic                     key_ext,
   output logic [7:0]               key_ascii,
   output logic                     key_event,
   output logic [BcdW*NDIGIT-1:0]   press_bcd,
   output logic                     err_overflow
);

   state_e                   state_q, state_d;
   logic [7:0]               byte_q, byte_d;
   logic                     brk_q, brk_d;
   logic                     ext_q, ext_d;
   logic                     key_down_q, key_down_d;
   logic [7:0]               key_scan_q, key_scan_d;
   logic                     key_ext_q, key_ext_d;
   logic                     key_event_q, key_event_d;
   logic [BcdW*NDIGIT-1:0]   press_bcd_q, press_bcd_d;
   logic                     err_overflow_q, err_overflow_d;

   logic [BcdW*NDIGIT-1:0]   bcd_inc;
   logic                     carry;
   logic                     same_key;
   logic [7:0]               rom_ascii;

   // State register and datapath flops
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q        <= StWait;
         byte_q         <= 8'h00;
         brk_q          <= 1'b0;
         ext_q          <= 1'b0;
         key_down_q     <= 1'b0;
         key_scan_q     <= 8'h00;
         key_ext_q      <= 1'b0;
         key_event_q    <= 1'b0;
         press_bcd_q    <= '0;
         err_overflow_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         byte_q         <= byte_d;
         brk_q          <= brk_d;
         ext_q          <= ext_d;
         key_down_q     <= key_down_d;
         key_scan_q     <= key_scan_d;
         key_ext_q      <= key_ext_d;
         key_event_q    <= key_event_d;
         press_bcd_q    <= press_bcd_d;
         err_overflow_q <= err_overflow_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StWait:  if (ps2_ready) state_d = StProc;
         StProc:  state_d = StWait;
         default: state_d = StWait;
      endcase
   end

   // FSM output: pop strobe, suppressed while reset is held
   always_comb begin
      nextdata_n = 1'b1;
      if (resetn && (state_q == StWait) && ps2_ready) nextdata_n = 1'b0;
   end

   // Ripple BCD increment; all-9s wraps to zero because the final carry is dropped
   always_comb begin
      carry   = 1'b1;
      bcd_inc = '0;
      for (int i = 0; i < int'(NDIGIT); i++) begin
         {carry, bcd_inc[BcdW*i +: BcdW]} = bcd_digit_inc(press_bcd_q[BcdW*i +: BcdW], carry);
      end
   end

   // A code matching the held key (including its extended-ness) is a repeat or its release
   assign same_key = key_down_q && (byte_q == key_scan_q) && (ext_q == key_ext_q);

   // Byte classification and counters
   always_comb begin
      byte_d         = byte_q;
      brk_d          = brk_q;
      ext_d          = ext_q;
      key_down_d     = key_down_q;
      key_scan_d     = key_scan_q;
      key_ext_d      = key_ext_q;
      key_event_d    = 1'b0;
      press_bcd_d    = press_bcd_q;
      err_overflow_d = err_overflow_q | ps2_overflow;
      unique case (state_q)
         StWait: begin
            if (ps2_ready) byte_d = ps2_data;
         end
         StProc: begin
            if (byte_q == EXT_CODE) begin
               ext_d = 1'b1;
            end else if (byte_q == BREAK_CODE) begin
               brk_d = 1'b1;
            end else if (brk_q) begin
               if (same_key) key_down_d = 1'b0;
               brk_d = 1'b0;
               ext_d = 1'b0;
            end else begin
               if (!same_key) begin
                  key_scan_d  = byte_q;
                  key_ext_d   = ext_q;
                  key_down_d  = 1'b1;
                  key_event_d = 1'b1;
                  press_bcd_d = bcd_inc;
               end
               ext_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   scancode_ascii u_ascii (
      .scan_i  (key_scan_q),
      .ascii_o (rom_ascii)
   );

   assign key_ascii    = key_ext_q ? 8'h00 : rom_ascii;
   assign key_down     = key_down_q;
   assign key_scan     = key_scan_q;
   assign key_ext      = key_ext_q;
   assign key_event    = key_event_q;
   assign press_bcd    = press_bcd_q;
   assign err_overflow = err_overflow_q;

endmodule
